// File: rtl/sample_stash_pkg.sv
// Shared constants and sizing helpers for the sample stash.
package stash_pkg;

  localparam int STASH_DEPTH_DEFAULT  = 5;
  localparam int SAMPLE_WIDTH_DEFAULT = 8;

  // Pointer width for a DEPTH-entry ring; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to hold 0..DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sample_stash_if.sv
// Sample bus between the upstream datapath and the stash.
interface sample_stash_if
  import stash_pkg::*;
#(
  parameter int DEPTH = STASH_DEPTH_DEFAULT,
  parameter int WIDTH = SAMPLE_WIDTH_DEFAULT
);
  logic [WIDTH-1:0]        sample_in;
  logic                    sample_in_valid;
  logic                    next_sample;
  logic [WIDTH-1:0]        sample_out;
  logic [cnt_w(DEPTH)-1:0] stored_count;

  modport master (
    output sample_in, sample_in_valid, next_sample,
    input  sample_out, stored_count
  );

  modport slave (
    input  sample_in, sample_in_valid, next_sample,
    output sample_out, stored_count
  );
endinterface

// File: rtl/sample_stash_ptr_ctrl.sv
// Write/read pointer and fill-count control for the circular stash.
// A write always wins over an advance; advances only walk written slots.
module stash_ptr_ctrl
  import stash_pkg::*;
#(
  parameter int DEPTH = STASH_DEPTH_DEFAULT,
  parameter int PW    = ptr_w(DEPTH),
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_stb,
  input  logic          nxt_stb,
  output logic          we,
  output logic [PW-1:0] waddr,
  output logic [PW-1:0] raddr,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rd_inc;

  // rd_ptr+1 in count width so it can be compared against the fill level.
  assign rd_inc = CW'(rd_ptr) + CW'(1);

  assign we    = wr_stb;
  assign waddr = wr_ptr;
  assign raddr = rd_ptr;

  // Pointer/count update: write shows the newest sample, advance steps cyclically.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (wr_stb) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (count != FULL) count <= count + CW'(1);
    end else if (nxt_stb && count != '0) begin
      if (count == FULL)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      else
        rd_ptr <= (rd_inc == count) ? '0 : PW'(rd_inc);
    end
  end

endmodule

// File: rtl/sample_stash.sv
// Circular sample stash: register array plus combinational display mux.
module sample_stash
  import stash_pkg::*;
#(
  parameter int DEPTH = STASH_DEPTH_DEFAULT,
  parameter int WIDTH = SAMPLE_WIDTH_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  sample_stash_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             we;
  logic [PW-1:0]    waddr, raddr;
  logic [CW-1:0]    count;

  stash_ptr_ctrl #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .wr_stb  (bus.sample_in_valid),
    .nxt_stb (bus.next_sample),
    .we      (we),
    .waddr   (waddr),
    .raddr   (raddr),
    .count   (count)
  );

  // Sample storage; cleared on reset so an empty stash displays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= bus.sample_in;
    end
  end

  assign bus.sample_out   = mem[raddr];
  assign bus.stored_count = count;

endmodule

// File: tb/tb_sample_stash.sv
// Directed bench for sample_stash (DEPTH=5, WIDTH=8).
module tb_sample_stash;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sample_stash_if #(.DEPTH(5), .WIDTH(8)) bus ();

  sample_stash #(.DEPTH(5), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [7:0] exp_out, input logic [2:0] exp_cnt);
    checks++;
    assert (bus.sample_out === exp_out) else begin
      failures++;
      $error("FAIL %s sample_out got=%h exp=%h", tag, bus.sample_out, exp_out);
    end
    checks++;
    assert (bus.stored_count === exp_cnt) else begin
      failures++;
      $error("FAIL %s stored_count got=%0d exp=%0d", tag, bus.stored_count, exp_cnt);
    end
  endtask

  // One clock with the given strobes, sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic n, input logic [7:0] d);
    bus.sample_in_valid = v;
    bus.next_sample     = n;
    bus.sample_in       = d;
    @(posedge clk);
    #1;
    bus.sample_in_valid = 1'b0;
    bus.next_sample     = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);  step(1'b1, 1'b0, d);    endtask
  task automatic nxt();                    step(1'b0, 1'b1, 8'h00); endtask
  task automatic idle();                   step(1'b0, 1'b0, 8'h00); endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 reset = 1'b1;
  endtask

  initial begin
    bus.sample_in = 8'h00;
    bus.sample_in_valid = 1'b0;
    bus.next_sample = 1'b0;

    // Held in reset with random traffic
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 1'($urandom), 8'($urandom));
      check("in_reset", 8'h00, 3'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idle();
    check("post_reset_idle", 8'h00, 3'd0);

    // Basic write/read
    wr(8'h10); check("wr10", 8'h10, 3'd1);
    nxt();     check("nxt_single", 8'h10, 3'd1);
    wr(8'h11); check("wr11", 8'h11, 3'd2);
    nxt();     check("nxt_a", 8'h10, 3'd2);
    nxt();     check("nxt_b", 8'h11, 3'd2);

    // Fill and rollover
    pulse_reset();
    check("reset_between", 8'h00, 3'd0);
    wr(8'h30); check("fill0", 8'h30, 3'd1);
    wr(8'h31); check("fill1", 8'h31, 3'd2);
    wr(8'h32); check("fill2", 8'h32, 3'd3);
    wr(8'h33); check("fill3", 8'h33, 3'd4);
    wr(8'h34); check("fill4", 8'h34, 3'd5);
    nxt(); check("roll0", 8'h30, 3'd5);
    nxt(); check("roll1", 8'h31, 3'd5);
    nxt(); check("roll2", 8'h32, 3'd5);
    nxt(); check("roll3", 8'h33, 3'd5);
    nxt(); check("roll4", 8'h34, 3'd5);
    nxt(); check("roll5", 8'h30, 3'd5);

    // Overwrite oldest when full
    wr(8'h40); check("overwrite", 8'h40, 3'd5);
    nxt();     check("after_ow", 8'h31, 3'd5);

    // Simultaneous strobes: write wins, no extra advance
    step(1'b1, 1'b1, 8'h55); check("simul", 8'h55, 3'd5);
    nxt();  check("after_simul", 8'h32, 3'd5);
    idle(); check("hold", 8'h32, 3'd5);

    // Async reset between edges drops output before next edge
    #2 reset = 1'b0;
    #1 check("async_rst", 8'h00, 3'd0);
    #1 reset = 1'b1;
    nxt(); check("nxt_empty", 8'h00, 3'd0);

    // Partial fill: advance wraps at count, not DEPTH
    wr(8'hA0); wr(8'hA1); wr(8'hA2);
    check("part_fill", 8'hA2, 3'd3);
    nxt(); check("part_wrap", 8'hA0, 3'd3);
    nxt(); check("part_step", 8'hA1, 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
